vga_display_ctrl: RTL and testbench
===================================

VGA_DISPLAY_CTRL -- requirements
Module: vga_display_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line as follows.
- H_ACTIVE, 640, visible pixels per line.
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixel ticks.
- V_ACTIVE, 480, visible lines per frame.
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines.
- TICK_DIV, 2, clk_50 cycles per pixel tick (>=1).
- RGB_W, 12, colour bus width.
- MIN_OFF_FRAMES, 4, minimum blanked frames once screen turns off (>=1).
- SYNC_POL, 0, active level of hsync/vsync.
REQ-002 Ports (name, direction, width, meaning), one per line as follows.
- clk_50, in, 1, single system clock.
- reset, in, 1, asynchronous active-high reset.
- screen_off, in, 1, level request to blank the display.
- x / y, out, 10 / 10, current pixel coordinates fed to the external pixel generator.
- rgb_in, in, RGB_W, pixel colour for the current x/y, combinational from the generator.
- hsync / vsync, out, 1, registered syncs to the connector.
- rgb, out, RGB_W, registered colour to the DAC.
- video_on, out, 1, registered visible-area flag.
- p_tick, out, 1, one-cycle pixel-tick strobe.
- frame_start, out, 1, one-cycle strobe on the tick entering x=0, y=0.
- is_off, out, 1, current display mode (1 = blanked).

Function
REQ-003 Tick divider: counts 0..TICK_DIV-1 on clk_50. p_tick is high for the single cycle at count TICK_DIV-1. TICK_DIV=1 holds p_tick high constantly.
REQ-004 Horizontal counter h: advances on p_tick over 0..H_ACTIVE+H_FP+H_SYNC+H_BP-1 and wraps to 0.
REQ-005 Vertical counter v: advances only on a p_tick where h wraps, over 0..V_ACTIVE+V_FP+V_SYNC+V_BP-1, and wraps to 0.
REQ-006 x and y equal h and v directly, with no register between counter and port.
REQ-007 Sync windows.
- Horizontal sync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- Vertical sync is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Active means level SYNC_POL; otherwise the line drives the inverse.
REQ-008 Visible area: visible = (h < H_ACTIVE) && (v < V_ACTIVE).
REQ-009 Output registers: hsync, vsync, video_on and rgb load only on p_tick, all from the same h/v. This gives one pixel-tick latency relative to x/y, with all four mutually aligned.
REQ-010 rgb load value: rgb loads rgb_in when visible and mode is ON; otherwise it loads all zeros.
REQ-011 frame_start asserts with the p_tick on which h and v both wrap to 0.
REQ-012 Mode FSM states and transitions.
- States: ON, OFF_HOLD, OFF.
- Transitions are evaluated only on a frame_start cycle.
- ON -> OFF_HOLD if screen_off=1; the hold counter loads MIN_OFF_FRAMES-1.
- OFF_HOLD: decrements the counter each frame_start; moves to OFF at 0, ignoring screen_off.
- OFF -> ON if screen_off=0.
REQ-013 is_off is 1 in OFF_HOLD and OFF. The mode change takes effect on the first pixel of the new frame, so no frame is ever partially blanked.
REQ-014 Syncs keep running in every mode; only rgb is forced to zero.
REQ-015 screen_off toggling between frame_starts has no effect; only its level on the frame_start cycle counts.
REQ-016 With MIN_OFF_FRAMES=1, the FSM enters OFF directly on the blanking frame_start; OFF_HOLD lasts zero frames.

Reset
REQ-017 reset asynchronously clears the following, regardless of tick phase.
- Divider, h and v.
- FSM to ON, hold counter to 0.
- rgb = 0, video_on = 0, p_tick = 0, frame_start = 0.
- hsync and vsync to the inactive level (~SYNC_POL).
REQ-018 After reset deasserts, the first p_tick occurs TICK_DIV cycles later, and counting starts from h=0, v=0.

Structure
REQ-019 The default 640x480@60 timing constants and the mode state encoding live in the shared package vga_pkg.
REQ-020 Counters, syncs and visible-area decode live in one sub-module, vga_timing. Output registers and the mode FSM sit in vga_display_ctrl.

Verification
REQ-021 Default parameters, line timing after reset: expect a 1600-clk hsync period and hsync low for 192 clk. The first hsync falling edge appears one tick after x reaches 656.
REQ-022 Frame timing: expect 525 lines per frame, vsync low for lines 490-491 (delayed one tick), and frame_start exactly every 840000 clk.
REQ-023 rgb_in = 12'hF0A constant: rgb = F0A only while video_on=1, and rgb = 000 at x=640..799 (one tick late).
REQ-024 Blanking mid-frame: screen_off=1 raised at y=100 of frame N. Frame N shows full colour; frames N+1..N+4 are blank with is_off=1. screen_off=0 raised during frame N+2 is ignored, and colour returns at frame N+5 only if screen_off=0 at that frame_start.
REQ-025 reset pulsed at x=300, y=200: outputs take reset values within the same cycle, and the next frame_start appears 840000 clk after release (plus the TICK_DIV phase).
REQ-026 TICK_DIV=1, MIN_OFF_FRAMES=1: p_tick is constant high, hsync period is 800 clk, and a single screen_off frame_start blanks exactly from the next frame.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and display-mode encoding
//
// Purpose: default 640x480@60 timing constants and the mode FSM state type,
//          shared by vga_timing and vga_display_ctrl.
// Ports:   none (package).
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    MODE_ON       = 2'd0,
    MODE_OFF_HOLD = 2'd1,
    MODE_OFF      = 2'd2
  } mode_e;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-tick divider, h/v counters, sync and visible decode
//
// Purpose: generates the pixel tick from clk_50 and walks the raster.
// Ports:
//   clk_50, reset       clock and asynchronous active-high reset
//   p_tick              registered one-cycle pixel strobe (constant 1 if TICK_DIV=1)
//   h, v                raw raster counters (unregistered view of the flops)
//   hsync_act/vsync_act h/v inside their sync windows (polarity-free)
//   visible             h/v inside the active picture
//   frame_wrap          p_tick on which both h and v wrap to 0
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int TICK_DIV = 2
) (
  input  logic       clk_50,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync_act,
  output logic       vsync_act,
  output logic       visible,
  output logic       frame_wrap
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p_tick_q, p_tick_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             h_wrap;

  always_comb begin
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    // Registered so that p_tick is 0 during reset even when TICK_DIV=1;
    // it is high exactly while cnt_q sits at its last value.
    p_tick_d = (cnt_d == CNT_LAST);
    h_wrap   = (h_q == H_LAST);
    h_d      = h_q;
    v_d      = v_q;
    if (p_tick_q) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      p_tick_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      cnt_q    <= cnt_d;
      p_tick_q <= p_tick_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  assign p_tick     = p_tick_q;
  assign h          = h_q;
  assign v          = v_q;
  assign hsync_act  = (h_q >= H_SYNC_LO) && (h_q <= H_SYNC_HI);
  assign vsync_act  = (v_q >= V_SYNC_LO) && (v_q <= V_SYNC_HI);
  assign visible    = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_wrap = p_tick_q && h_wrap && (v_q == V_LAST);

endmodule

// File: rtl/vga_display_ctrl.sv
// rtl/vga_display_ctrl.sv - VGA display controller with frame-aligned blanking
//
// Purpose: drives registered syncs/colour to the connector and blanks the
//          picture on whole-frame boundaries with a minimum off time.
// Ports:
//   clk_50, reset   clock and asynchronous active-high reset
//   screen_off      blank request, sampled only on frame_start
//   x, y            current pixel coordinates to the pixel generator
//   rgb_in          colour for x/y from the generator
//   hsync, vsync    registered syncs, active level SYNC_POL
//   rgb, video_on   registered colour and visible flag (one tick behind x/y)
//   p_tick          pixel-tick strobe
//   frame_start     strobe on the tick that enters x=0, y=0
//   is_off          1 while the display is blanked
module vga_display_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_DEF,
  parameter int H_FP           = H_FP_DEF,
  parameter int H_SYNC         = H_SYNC_DEF,
  parameter int H_BP           = H_BP_DEF,
  parameter int V_ACTIVE       = V_ACTIVE_DEF,
  parameter int V_FP           = V_FP_DEF,
  parameter int V_SYNC         = V_SYNC_DEF,
  parameter int V_BP           = V_BP_DEF,
  parameter int TICK_DIV       = 2,
  parameter int RGB_W          = 12,
  parameter int MIN_OFF_FRAMES = 4,
  parameter bit SYNC_POL       = 1'b0
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             screen_off,
  output logic [9:0]       x,
  output logic [9:0]       y,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic             video_on,
  output logic             p_tick,
  output logic             frame_start,
  output logic             is_off
);

  localparam int HOLD_W = (MIN_OFF_FRAMES > 1) ? $clog2(MIN_OFF_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_OFF_FRAMES - 1);

  logic       tick;
  logic [9:0] h, v;
  logic       hsync_act, vsync_act, visible, frame_wrap;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .TICK_DIV (TICK_DIV)
  ) u_timing (
    .clk_50     (clk_50),
    .reset      (reset),
    .p_tick     (tick),
    .h          (h),
    .v          (v),
    .hsync_act  (hsync_act),
    .vsync_act  (vsync_act),
    .visible    (visible),
    .frame_wrap (frame_wrap)
  );

  mode_e             state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              video_on_q, video_on_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;

  // Mode FSM. It only moves on the wrap tick, so the new mode is in force
  // from the very first pixel of the next frame.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (frame_wrap) begin
      case (state_q)
        MODE_ON: begin
          if (screen_off) begin
            hold_d  = HOLD_INIT;
            state_d = (HOLD_INIT == '0) ? MODE_OFF : MODE_OFF_HOLD;
          end
        end
        MODE_OFF_HOLD: begin
          // The hold ends on the frame_start that brings the count to 0.
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) begin
            state_d = MODE_OFF;
          end
        end
        MODE_OFF: begin
          if (!screen_off) begin
            state_d = MODE_ON;
          end
        end
        default: begin
          state_d = MODE_ON;
          hold_d  = '0;
        end
      endcase
    end
  end

  // All four outputs load from the same h/v on the tick, staying aligned.
  always_comb begin
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    rgb_d      = rgb_q;
    if (tick) begin
      hsync_d    = hsync_act ? SYNC_POL : ~SYNC_POL;
      vsync_d    = vsync_act ? SYNC_POL : ~SYNC_POL;
      video_on_d = visible;
      rgb_d      = (visible && (state_q == MODE_ON)) ? rgb_in : '0;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q    <= MODE_ON;
      hold_q     <= '0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      video_on_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      rgb_q      <= rgb_d;
    end
  end

  assign x           = h;
  assign y           = v;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign rgb         = rgb_q;
  assign p_tick      = tick;
  assign frame_start = frame_wrap;
  assign is_off      = (state_q != MODE_ON);

endmodule

// File: tb/tb_vga_display_ctrl.sv
// tb/tb_vga_display_ctrl.sv - directed self-checking bench for vga_display_ctrl
//
// Purpose: two reduced-timing instances (16x8 raster). A: TICK_DIV=2,
//          MIN_OFF_FRAMES=4, SYNC_POL=0. B: TICK_DIV=1, MIN_OFF_FRAMES=1,
//          SYNC_POL=1. Line = 16 ticks, frame = 128 ticks.
// Ports:   none.
module tb_vga_display_ctrl;

  localparam int BOUND = 4000;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  logic        rst_a, rst_b, soff_a, soff_b;
  logic [11:0] rgb_in;

  logic [9:0]  x_a, y_a, x_b, y_b;
  logic        hsync_a, vsync_a, video_on_a, p_tick_a, fs_a, is_off_a;
  logic        hsync_b, vsync_b, video_on_b, p_tick_b, fs_b, is_off_b;
  logic [11:0] rgb_a, rgb_b;

  vga_display_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .TICK_DIV(2), .RGB_W(12), .MIN_OFF_FRAMES(4), .SYNC_POL(1'b0)
  ) dut_a (
    .clk_50(clk_50), .reset(rst_a), .screen_off(soff_a),
    .x(x_a), .y(y_a), .rgb_in(rgb_in),
    .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a), .video_on(video_on_a),
    .p_tick(p_tick_a), .frame_start(fs_a), .is_off(is_off_a)
  );

  vga_display_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .TICK_DIV(1), .RGB_W(12), .MIN_OFF_FRAMES(1), .SYNC_POL(1'b1)
  ) dut_b (
    .clk_50(clk_50), .reset(rst_b), .screen_off(soff_b),
    .x(x_b), .y(y_b), .rgb_in(rgb_in),
    .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b), .video_on(video_on_b),
    .p_tick(p_tick_b), .frame_start(fs_b), .is_off(is_off_b)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_mis++;
    $error("FAIL %s timeout after %0d cycles", tag, BOUND);
  endtask

  function automatic logic [9:0] gx(input bit s);
    return s ? x_b : x_a;
  endfunction

  function automatic logic [9:0] gy(input bit s);
    return s ? y_b : y_a;
  endfunction

  function automatic logic gsync(input bit s, input bit vert);
    if (vert) return s ? vsync_b : vsync_a;
    return s ? hsync_b : hsync_a;
  endfunction

  function automatic logic gfs(input bit s);
    return s ? fs_b : fs_a;
  endfunction

  task automatic wait_xy(input bit s, input int xa, input int ya);
    int n = 0;
    do begin
      @(negedge clk_50);
      n++;
    end while (!(gx(s) == xa[9:0] && gy(s) == ya[9:0]) && n < BOUND);
    if (n >= BOUND) timeout("wait_xy");
  endtask

  task automatic next_frame(input bit s);
    int n = 0;
    do begin
      @(negedge clk_50);
      n++;
    end while (!gfs(s) && n < BOUND);
    if (n >= BOUND) timeout("next_frame");
  endtask

  task automatic wait_lvl(input bit s, input bit vert, input logic lvl);
    int n = 0;
    while (gsync(s, vert) !== lvl && n < BOUND) begin
      @(negedge clk_50);
      n++;
    end
    if (n >= BOUND) timeout("wait_lvl");
  endtask

  // Period from one active edge to the next, active width in cycles, and
  // the coordinates seen on the first active cycle.
  task automatic sync_meas(input bit s, input bit vert, input logic pol,
                           output int period, output int act,
                           output int fx, output int fy);
    int t0;
    wait_lvl(s, vert, ~pol);
    wait_lvl(s, vert, pol);
    t0  = cyc;
    fx  = int'(gx(s));
    fy  = int'(gy(s));
    act = 0;
    while (gsync(s, vert) === pol && act < BOUND) begin
      act++;
      @(negedge clk_50);
    end
    wait_lvl(s, vert, pol);
    period = cyc - t0;
  endtask

  int per, act, fx, fy, t0;

  initial begin
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    soff_a = 1'b0;
    soff_b = 1'b0;
    rgb_in = 12'hF0A;
    repeat (3) @(negedge clk_50);

    // Reset state
    chk("rst_a_x", 32'(x_a), 0);
    chk("rst_a_y", 32'(y_a), 0);
    chk("rst_a_ptick", 32'(p_tick_a), 0);
    chk("rst_a_fs", 32'(fs_a), 0);
    chk("rst_a_hsync", 32'(hsync_a), 1);
    chk("rst_a_vsync", 32'(vsync_a), 1);
    chk("rst_a_rgb", 32'(rgb_a), 0);
    chk("rst_a_video_on", 32'(video_on_a), 0);
    chk("rst_a_is_off", 32'(is_off_a), 0);
    chk("rst_b_ptick", 32'(p_tick_b), 0);
    chk("rst_b_hsync", 32'(hsync_b), 0);
    chk("rst_b_vsync", 32'(vsync_b), 0);

    // Release: x starts at 0 and first advances after TICK_DIV=2 edges
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk_50);
    chk("rel_e1_ptick", 32'(p_tick_a), 1);
    chk("rel_e1_x", 32'(x_a), 0);
    @(negedge clk_50);
    chk("rel_e2_x", 32'(x_a), 1);
    chk("rel_e2_ptick", 32'(p_tick_a), 0);

    // A line timing: 16 ticks * 2 = 32 clk, 3 ticks low = 6 clk, fall at x=11
    sync_meas(1'b0, 1'b0, 1'b0, per, act, fx, fy);
    chk("a_hsync_period", 32'(per), 32);
    chk("a_hsync_low", 32'(act), 6);
    chk("a_hsync_fall_x", 32'(fx), 11);

    // A frame timing: 8 lines = 256 clk, 2 lines low = 64 clk, fall at y=5 x=1
    sync_meas(1'b0, 1'b1, 1'b0, per, act, fx, fy);
    chk("a_vsync_period", 32'(per), 256);
    chk("a_vsync_low", 32'(act), 64);
    chk("a_vsync_fall_y", 32'(fy), 5);
    chk("a_vsync_fall_x", 32'(fx), 1);

    next_frame(1'b0);
    t0 = cyc;
    next_frame(1'b0);
    chk("a_frame_period", 32'(cyc - t0), 256);

    // Colour window, one tick behind x/y
    wait_xy(1'b0, 8, 0);
    chk("rgb_x8_y0", 32'(rgb_a), 32'h0F0A);
    chk("von_x8_y0", 32'(video_on_a), 1);
    wait_xy(1'b0, 9, 0);
    chk("rgb_x9_y0", 32'(rgb_a), 0);
    chk("von_x9_y0", 32'(video_on_a), 0);
    wait_xy(1'b0, 0, 1);
    chk("rgb_x0_y1", 32'(rgb_a), 0);
    wait_xy(1'b0, 1, 1);
    chk("rgb_x1_y1", 32'(rgb_a), 32'h0F0A);
    chk("von_x1_y1", 32'(video_on_a), 1);
    wait_xy(1'b0, 7, 3);
    chk("rgb_x7_y3", 32'(rgb_a), 32'h0F0A);
    wait_xy(1'b0, 1, 4);
    chk("rgb_x1_y4", 32'(rgb_a), 0);
    chk("von_x1_y4", 32'(video_on_a), 0);

    // Blanking: request mid-frame N, N stays coloured, N+1..N+4 blank
    next_frame(1'b0);
    wait_xy(1'b0, 0, 1);
    soff_a = 1'b1;
    wait_xy(1'b0, 1, 2);
    chk("blk_n_rgb", 32'(rgb_a), 32'h0F0A);
    chk("blk_n_is_off", 32'(is_off_a), 0);
    next_frame(1'b0);
    wait_xy(1'b0, 1, 1);
    chk("blk_n1_is_off", 32'(is_off_a), 1);
    chk("blk_n1_rgb", 32'(rgb_a), 0);
    chk("blk_n1_von", 32'(video_on_a), 1);
    next_frame(1'b0);
    wait_xy(1'b0, 1, 1);
    soff_a = 1'b0;
    chk("blk_n2_is_off", 32'(is_off_a), 1);
    chk("blk_n2_rgb", 32'(rgb_a), 0);
    next_frame(1'b0);
    wait_xy(1'b0, 1, 1);
    chk("blk_n3_is_off", 32'(is_off_a), 1);
    chk("blk_n3_rgb", 32'(rgb_a), 0);
    next_frame(1'b0);
    wait_xy(1'b0, 1, 1);
    chk("blk_n4_is_off", 32'(is_off_a), 1);
    chk("blk_n4_rgb", 32'(rgb_a), 0);
    wait_xy(1'b0, 1, 5);
    chk("blk_n4_vsync", 32'(vsync_a), 0);
    next_frame(1'b0);
    wait_xy(1'b0, 1, 1);
    chk("blk_n5_is_off", 32'(is_off_a), 0);
    chk("blk_n5_rgb", 32'(rgb_a), 32'h0F0A);

    // Mid-frame reset while in the hold state
    soff_a = 1'b1;
    next_frame(1'b0);
    wait_xy(1'b0, 5, 2);
    chk("mrst_pre_is_off", 32'(is_off_a), 1);
    rst_a = 1'b1;
    #1;
    chk("mrst_x", 32'(x_a), 0);
    chk("mrst_y", 32'(y_a), 0);
    chk("mrst_rgb", 32'(rgb_a), 0);
    chk("mrst_von", 32'(video_on_a), 0);
    chk("mrst_hsync", 32'(hsync_a), 1);
    chk("mrst_ptick", 32'(p_tick_a), 0);
    chk("mrst_is_off", 32'(is_off_a), 0);
    soff_a = 1'b0;
    @(negedge clk_50);
    rst_a = 1'b0;
    t0 = cyc;
    // 128 ticks, consumed on edges 2,4,..; the wrap tick is visible after edge 255
    next_frame(1'b0);
    chk("mrst_first_fs", 32'(cyc - t0), 255);

    // B: TICK_DIV=1 -> p_tick constant high
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_50);
      chk("b_ptick_high", 32'(p_tick_b), 1);
    end
    sync_meas(1'b1, 1'b0, 1'b1, per, act, fx, fy);
    chk("b_hsync_period", 32'(per), 16);
    chk("b_hsync_active", 32'(act), 3);
    chk("b_hsync_edge_x", 32'(fx), 11);
    next_frame(1'b1);
    t0 = cyc;
    next_frame(1'b1);
    chk("b_frame_period", 32'(cyc - t0), 128);

    // B: MIN_OFF_FRAMES=1 blanks exactly the next frame
    wait_xy(1'b1, 0, 1);
    soff_b = 1'b1;
    wait_xy(1'b1, 1, 3);
    chk("b_blk_pre_is_off", 32'(is_off_b), 0);
    chk("b_blk_pre_rgb", 32'(rgb_b), 32'h0F0A);
    next_frame(1'b1);
    wait_xy(1'b1, 1, 1);
    chk("b_blk_is_off", 32'(is_off_b), 1);
    chk("b_blk_rgb", 32'(rgb_b), 0);
    wait_xy(1'b1, 0, 2);
    soff_b = 1'b0;
    next_frame(1'b1);
    wait_xy(1'b1, 1, 1);
    chk("b_blk_post_is_off", 32'(is_off_b), 0);
    chk("b_blk_post_rgb", 32'(rgb_b), 32'h0F0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
